// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encoding and helpers for the oversampling UART receiver.
package uart_pkg;

  // Parity modes selected by the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } rx_state_e;

  // A FIFO word carries {break, parity_err, frame_err, data}.
  function automatic int fifo_width(input int data_bits);
    return data_bits + 3;
  endfunction

  // 2-of-3 majority vote used to clean up each bit sample.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity check: odd needs XOR(data, bit)=1, even needs XOR(data, bit)=0.
  function automatic logic parity_err(input logic [7:0] data, input logic par_bit, input int mode);
    logic x;
    x = (^data) ^ par_bit;
    case (mode)
      PAR_ODD:  parity_err = ~x;
      PAR_EVEN: parity_err = x;
      default:  parity_err = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags, occupancy level
// and an overflow strobe for pushes that had to be dropped.
module sync_fifo
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // Pop only when data is held; a push into a full FIFO is accepted only if a pop frees the slot.
  always_comb begin
    rd_en_s  = pop & ~empty_r;
    wr_en_s  = push & (~full_r | rd_en_s);
    overflow = push & full_r & ~rd_en_s;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers, occupancy and registered flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_V);
      empty_r <= (count_nxt_s == {(AW+1){1'b0}});
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign level = count_r;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver. Synchronises the RX pin, derives an
// oversample tick from the system clock, majority-votes each bit at mid-bit and
// queues {break, parity_err, frame_err, data} words in a small FIFO.
module uart_rx_os
#(
  parameter int CLKS_PER_TICK = 4,
  parameter int OS            = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_break,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          clr_overrun,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);
  import uart_pkg::*;

  localparam int WORD_W = fifo_width(DATA_BITS);
  localparam int TW     = $clog2(CLKS_PER_TICK);
  localparam int PW     = $clog2(OS);
  localparam int BW     = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(OS - 1);
  localparam logic [PW-1:0] PH_V0     = PW'(OS/2 - 1);
  localparam logic [PW-1:0] PH_V1     = PW'(OS/2);
  localparam logic [PW-1:0] PH_V2     = PW'(OS/2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  // Synchroniser and edge detect
  logic sync1_r;
  logic sync2_r;
  logic rxs_d_r;
  logic fall_s;

  // Timing
  logic [TW-1:0] tick_cnt_r;
  logic [PW-1:0] ph_r;
  logic          tick_s;
  logic          vote_tick_s;
  logic          start_s;

  // FSM and frame datapath
  rx_state_e            state_r;
  rx_state_e            state_nxt_s;
  logic                 v0_r;
  logic                 v1_r;
  logic                 vote_s;
  logic [DATA_BITS-1:0] shreg_r;
  logic [BW-1:0]        bit_cnt_r;
  logic                 par_bit_r;
  logic                 stop_cnt_r;
  logic                 stop0_r;
  logic                 ferr_r;
  logic                 final_stop_s;
  logic                 first_stop_s;
  logic                 frame_err_s;
  logic                 brk_s;
  logic                 par_err_s;
  logic [7:0]           data8_s;
  logic [WORD_W-1:0]    word_nxt_s;

  // Push pipeline and status
  logic              push_r;
  logic [WORD_W-1:0] word_r;
  logic              busy_r;
  logic              overrun_r;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_ovf_s;
  logic [WORD_W-1:0] head_s;

  // Two-flop synchroniser (idle-high reset) plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      rxs_d_r <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      rxs_d_r <= sync2_r;
    end
  end

  // Tick, vote and end-of-word decode; the word is assembled here for the push register.
  always_comb begin
    fall_s       = rxs_d_r & ~sync2_r;
    start_s      = (state_r == IDLE) & fall_s;
    tick_s       = (tick_cnt_r == TICK_LAST);
    vote_tick_s  = tick_s & (ph_r == PH_V2);
    vote_s       = maj3(v0_r, v1_r, sync2_r);
    final_stop_s = (state_r == STOP) & vote_tick_s & (stop_cnt_r == STOP_LAST);
    if (stop_cnt_r == 1'b0) begin
      first_stop_s = vote_s;
    end else begin
      first_stop_s = stop0_r;
    end
    frame_err_s = ferr_r | ~vote_s;
    brk_s       = (shreg_r == {DATA_BITS{1'b0}}) & ~par_bit_r & ~first_stop_s;
    data8_s     = 8'd0;
    data8_s[DATA_BITS-1:0] = shreg_r;
    par_err_s   = parity_err(data8_s, par_bit_r, PARITY) & ~brk_s;
    word_nxt_s  = {brk_s, par_err_s, frame_err_s, shreg_r};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: one vote per bit, leave mid-stop so the next start edge is not missed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s) state_nxt_s = START;
        else        state_nxt_s = IDLE;
      end
      START: begin
        if (vote_tick_s) begin
          if (vote_s) state_nxt_s = IDLE;
          else        state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (vote_tick_s && (bit_cnt_r == BIT_LAST)) begin
          if (PARITY != PAR_NONE) state_nxt_s = uart_pkg::PARITY;
          else                    state_nxt_s = STOP;
        end else begin
          state_nxt_s = DATA;
        end
      end
      uart_pkg::PARITY: begin
        if (vote_tick_s) state_nxt_s = STOP;
        else             state_nxt_s = uart_pkg::PARITY;
      end
      STOP: begin
        if (final_stop_s) begin
          if (brk_s) state_nxt_s = BRK;
          else       state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOP;
        end
      end
      BRK: begin
        if (sync2_r) state_nxt_s = IDLE;
        else         state_nxt_s = BRK;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Tick generator, bit phase, vote samples and per-frame shift/count/error state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_r <= {TW{1'b0}};
      ph_r       <= {PW{1'b0}};
      v0_r       <= 1'b1;
      v1_r       <= 1'b1;
      shreg_r    <= {DATA_BITS{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      par_bit_r  <= 1'b0;
      stop_cnt_r <= 1'b0;
      stop0_r    <= 1'b1;
      ferr_r     <= 1'b0;
    end else if (start_s) begin
      tick_cnt_r <= {TW{1'b0}};
      ph_r       <= {PW{1'b0}};
      shreg_r    <= {DATA_BITS{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      par_bit_r  <= 1'b0;
      stop_cnt_r <= 1'b0;
      stop0_r    <= 1'b1;
      ferr_r     <= 1'b0;
    end else begin
      if (tick_s) begin
        tick_cnt_r <= {TW{1'b0}};
        if (ph_r == PH_LAST) ph_r <= {PW{1'b0}};
        else                 ph_r <= ph_r + PW'(1);
        if (ph_r == PH_V0) v0_r <= sync2_r;
        if (ph_r == PH_V1) v1_r <= sync2_r;
      end else begin
        tick_cnt_r <= tick_cnt_r + TW'(1);
      end
      if (vote_tick_s && (state_r == DATA)) begin
        shreg_r   <= {vote_s, shreg_r[DATA_BITS-1:1]};
        bit_cnt_r <= bit_cnt_r + BW'(1);
      end
      if (vote_tick_s && (state_r == uart_pkg::PARITY)) begin
        par_bit_r <= vote_s;
      end
      if (vote_tick_s && (state_r == STOP)) begin
        stop_cnt_r <= stop_cnt_r + 1'b1;
        ferr_r     <= frame_err_s;
        if (stop_cnt_r == 1'b0) stop0_r <= vote_s;
      end
    end
  end

  // Register the finished word so the FIFO push lands one clock after the last stop vote.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_r <= 1'b0;
      word_r <= {WORD_W{1'b0}};
    end else begin
      push_r <= final_stop_s;
      if (final_stop_s) word_r <= word_nxt_s;
    end
  end

  // Busy flag follows the FSM; sticky overrun where a new drop beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      if (fifo_ovf_s)       overrun_r <= 1'b1;
      else if (clr_overrun) overrun_r <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_r),
    .push_data (word_r),
    .pop       (rx_ready),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .overflow  (fifo_ovf_s),
    .level     (rx_level)
  );

  assign {rx_break, rx_parity_err, rx_frame_err, rx_data} = head_s;
  assign rx_valid   = ~fifo_empty_s;
  assign rx_busy    = busy_r;
  assign rx_overrun = overrun_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed self-checking bench for uart_rx_os (4 clk/tick, 16x, 8E1, depth 4).
module tb_uart_rx_os;

  localparam int CPT      = 4;
  localparam int OSR      = 16;
  localparam int BIT_CLKS = CPT * OSR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       rx_ready;
  logic       clr_overrun;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_break;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_busy;
  logic [2:0] rx_level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLKS_PER_TICK (CPT),
    .OS            (OSR),
    .DATA_BITS     (8),
    .PARITY        (2),
    .STOP_BITS     (1),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (uart_rx),
    .rx_data       (rx_data),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_break      (rx_break),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_overrun    (rx_overrun),
    .clr_overrun   (clr_overrun),
    .rx_busy       (rx_busy),
    .rx_level      (rx_level)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8E1-style frame from a negedge; spike_bit selects a bit that gets a 1-clock high spike.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp, input int spike_bit);
    logic [10:0] bits;
    bits = {stp, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < BIT_CLKS; j++) begin
        uart_rx = (k == spike_bit && j == 36) ? 1'b1 : bits[k];
        @(negedge clk);
      end
    end
    uart_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [7:0] d, input logic fe, input logic pe, input logic br);
    chk_eq({tag, "_data"}, 32'(rx_data), 32'(d));
    chk_eq({tag, "_ferr"}, 32'(rx_frame_err), 32'(fe));
    chk_eq({tag, "_perr"}, 32'(rx_parity_err), 32'(pe));
    chk_eq({tag, "_brk"}, 32'(rx_break), 32'(br));
    chk_eq({tag, "_valid"}, 32'(rx_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] heads [4];
    logic       ovr_par [5];
    ovr_par = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    heads   = '{8'h11, 8'h12, 8'h13, 8'h15};

    rst_n = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_valid", 32'(rx_valid), 32'd0);
    chk_eq("rst_level", 32'(rx_level), 32'd0);
    chk_eq("rst_busy", 32'(rx_busy), 32'd0);
    chk_eq("rst_ovr", 32'(rx_overrun), 32'd0);
    chk_eq("rst_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // 0xA5, even parity bit 0, plus start-to-busy latency
    fork
      send_frame(8'hA5, 1'b0, 1'b1, -1);
      begin
        repeat (2) @(posedge clk); #1;
        chk_eq("busy_lat2", 32'(rx_busy), 32'd0);
        @(posedge clk); #1;
        chk_eq("busy_lat3", 32'(rx_busy), 32'd1);
      end
    join
    idle(64);
    chk_word("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    chk_eq("a5_level", 32'(rx_level), 32'd1);
    chk_eq("a5_busy_after", 32'(rx_busy), 32'd0);
    pop_one();
    chk_eq("a5_pop_valid", 32'(rx_valid), 32'd0);
    chk_eq("a5_pop_level", 32'(rx_level), 32'd0);

    // parity error: 0x01 with parity bit 0
    send_frame(8'h01, 1'b0, 1'b1, -1);
    idle(64);
    chk_word("perr", 8'h01, 1'b0, 1'b1, 1'b0);
    pop_one();

    // frame error: 0x3C with low stop bit
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(64);
    chk_word("ferr", 8'h3C, 1'b1, 1'b0, 1'b0);
    pop_one();

    // 20-clock glitch is a false start
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    chk_eq("glitch_busy", 32'(rx_busy), 32'd1);
    idle(100);
    chk_eq("glitch_idle", 32'(rx_busy), 32'd0);
    chk_eq("glitch_valid", 32'(rx_valid), 32'd0);

    // single-clock spike on data bit 1 (a 0 in 0xA5) is voted away
    send_frame(8'hA5, 1'b0, 1'b1, 2);
    idle(64);
    chk_word("spike", 8'hA5, 1'b0, 1'b0, 1'b0);
    pop_one();

    // break: line low for two frame times
    uart_rx = 1'b0;
    repeat (1000) @(negedge clk);
    chk_eq("brk_busy", 32'(rx_busy), 32'd1);
    repeat (408) @(negedge clk);
    idle(100);
    chk_eq("brk_level", 32'(rx_level), 32'd1);
    chk_word("brk", 8'h00, 1'b1, 1'b0, 1'b1);
    chk_eq("brk_idle", 32'(rx_busy), 32'd0);
    pop_one();
    send_frame(8'h55, 1'b0, 1'b1, -1);
    idle(64);
    chk_word("post_brk", 8'h55, 1'b0, 1'b0, 1'b0);
    chk_eq("post_brk_level", 32'(rx_level), 32'd1);
    pop_one();

    // overrun: five words into a depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), ovr_par[i], 1'b1, -1);
      idle(16);
    end
    chk_eq("ovr_level", 32'(rx_level), 32'd4);
    chk_eq("ovr_flag", 32'(rx_overrun), 32'd1);
    chk_eq("ovr_head0", 32'(rx_data), 32'h10);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk_eq("ovr_clr", 32'(rx_overrun), 32'd0);
    chk_eq("ovr_clr_level", 32'(rx_level), 32'd4);

    // full FIFO: pop in the very cycle the 0x15 word is pushed
    fork
      send_frame(8'h15, 1'b1, 1'b1, -1);
      begin
        repeat (683) @(posedge clk);
        @(negedge clk) rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
      end
    join
    idle(16);
    chk_eq("pp_level", 32'(rx_level), 32'd4);
    chk_eq("pp_ovr", 32'(rx_overrun), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("drain_head%0d", i), 32'(rx_data), 32'(heads[i]));
      pop_one();
    end
    chk_eq("drain_level", 32'(rx_level), 32'd0);
    chk_eq("drain_valid", 32'(rx_valid), 32'd0);
    pop_one();
    chk_eq("ready_empty_level", 32'(rx_level), 32'd0);

    // reset in the middle of a frame with a word queued
    send_frame(8'h42, 1'b0, 1'b1, -1);
    idle(16);
    chk_eq("pre_rst_level", 32'(rx_level), 32'd1);
    uart_rx = 1'b0;
    repeat (200) @(negedge clk);
    chk_eq("pre_rst_busy", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_eq("mrst_valid", 32'(rx_valid), 32'd0);
    chk_eq("mrst_level", 32'(rx_level), 32'd0);
    chk_eq("mrst_busy", 32'(rx_busy), 32'd0);
    chk_eq("mrst_data", 32'(rx_data), 32'd0);
    chk_eq("mrst_flags", 32'({rx_frame_err, rx_parity_err, rx_break, rx_overrun}), 32'd0);
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk_eq("post_rst_busy", 32'(rx_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
